// File: rtl/eerrl_pkg.sv
// Shared definitions for the receive-side heartbeat parser.
// Optional feature macro: HB_CHECKSUM_EN (adds a trailing XOR checksum word).
package eerrl_pkg;

   localparam int unsigned WORD_WIDTH = 16;
   localparam int unsigned ERR_W      = 8;

   // Message type codes carried in header[15:8]
   localparam logic [7:0] MSG_HB   = 8'h01;
   localparam logic [7:0] MSG_DATA = 8'h02;
   localparam logic [7:0] MSG_JOIN = 8'h03;

   // Hop count meaning "CH unreachable"
   localparam logic [WORD_WIDTH-1:0] HOPS_INF = 16'hFFFF;

   // Header word layout
   typedef struct packed {
      logic [7:0] msg_type;
      logic [7:0] round;
   } hb_hdr_t;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_HDR    = 4'd1,
      S_SRC    = 4'd2,
      S_HOPS   = 4'd3,
      S_QV     = 4'd4,
      S_CHK    = 4'd5,
      S_DECIDE = 4'd6,
      S_RND    = 4'd7,
      S_EMIT   = 4'd8,
      S_DRAIN  = 4'd9
   } hb_state_t;

   // Hop count as seen from this node: one more than the sender's, saturating
   function automatic logic [WORD_WIDTH-1:0] hops_inc(input logic [WORD_WIDTH-1:0] h);
      return (h == HOPS_INF) ? HOPS_INF : h + WORD_WIDTH'(1);
   endfunction

   // States in which the parser takes words from the stream
   function automatic logic accepts_word(input hb_state_t s);
      return (s == S_HDR) || (s == S_SRC) || (s == S_HOPS) || (s == S_QV) ||
             (s == S_CHK) || (s == S_DRAIN);
   endfunction

endpackage

// File: rtl/hb_rx_parser_chksum.sv
// Running XOR accumulator over the first four packet words.
// Only instantiated when HB_CHECKSUM_EN is defined.
module hb_chksum
   import eerrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] data,
   output logic                  match_c
);

   logic [WORD_WIDTH-1:0] acc;

   // Accumulate XOR of accepted words; cleared between packets
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ data;
      end
   end

   // Current word matches the accumulated checksum
   assign match_c = (acc == data);

endmodule

// File: rtl/hb_rx_parser.sv
// Cluster-head heartbeat filter feeding the known-CH table.
// Optional feature macro: HB_CHECKSUM_EN (5-word packets with XOR checksum in w4).
module hb_rx_parser
   import eerrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [WORD_WIDTH-1:0] my_id,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic [WORD_WIDTH-1:0] rx_data,
   input  logic                  rx_last,
   output logic                  en_KCH,
   output logic                  HB_reset,
   output logic [WORD_WIDTH-1:0] fCH_ID,
   output logic [WORD_WIDTH-1:0] fCH_Hops,
   output logic [WORD_WIDTH-1:0] fCH_QValue,
   output logic [WORD_WIDTH-1:0] hb_count,
   output logic [ERR_W-1:0]      err_count
);

   hb_state_t             state, state_nxt;
   hb_hdr_t               hdr;
   logic                  hs;

   logic [7:0]            round_q;
   logic [WORD_WIDTH-1:0] src_q;
   logic [WORD_WIDTH-1:0] hops_q;
   logic [WORD_WIDTH-1:0] qv_q;
   logic                  last_q;
   logic [7:0]            rnd_q;
   logic                  rnd_valid;

   logic                  cap_hdr, cap_src, cap_hops, cap_qv, set_last, err_inc;

   assign hs  = rx_valid & rx_ready;
   assign hdr = hb_hdr_t'(rx_data);

`ifdef HB_CHECKSUM_EN
   logic chk_match_c;

   hb_chksum u_chksum (
      .clk     (clk),
      .nrst    (nrst),
      .clr     (state == S_IDLE),
      .en      (hs && ((state == S_HDR) || (state == S_SRC) ||
                       (state == S_HOPS) || (state == S_QV))),
      .data    (rx_data),
      .match_c (chk_match_c)
   );
`endif

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-word capture/error decisions
   always_comb begin
      state_nxt = state;
      cap_hdr   = 1'b0;
      cap_src   = 1'b0;
      cap_hops  = 1'b0;
      cap_qv    = 1'b0;
      set_last  = 1'b0;
      err_inc   = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_HDR;
         S_HDR: if (hs) begin
            cap_hdr = 1'b1;
            if (hdr.msg_type != MSG_HB) begin
               state_nxt = rx_last ? S_IDLE : S_DRAIN;
            end else if (rx_last) begin
               err_inc   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_SRC;
            end
         end
         S_SRC: if (hs) begin
            cap_src = 1'b1;
            if (rx_last) begin
               err_inc   = 1'b1;
               state_nxt = S_IDLE;
            end else if (rx_data == my_id) begin
               state_nxt = S_DRAIN;
            end else begin
               state_nxt = S_HOPS;
            end
         end
         S_HOPS: if (hs) begin
            cap_hops = 1'b1;
            if (rx_last) begin
               err_inc   = 1'b1;
               state_nxt = S_IDLE;
            end else if (rx_data == HOPS_INF) begin
               state_nxt = S_DRAIN;
            end else begin
               state_nxt = S_QV;
            end
         end
         S_QV: if (hs) begin
            cap_qv = 1'b1;
`ifdef HB_CHECKSUM_EN
            if (rx_last) begin
               err_inc   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_CHK;
            end
`else
            set_last  = 1'b1;
            state_nxt = S_DECIDE;
`endif
         end
         S_CHK: begin
`ifdef HB_CHECKSUM_EN
            if (hs) begin
               if (chk_match_c) begin
                  set_last  = 1'b1;
                  state_nxt = S_DECIDE;
               end else begin
                  err_inc   = 1'b1;
                  state_nxt = rx_last ? S_IDLE : S_DRAIN;
               end
            end
`else
            state_nxt = S_IDLE;
`endif
         end
         S_DECIDE: state_nxt = (!rnd_valid || (round_q != rnd_q)) ? S_RND : S_EMIT;
         S_RND:    state_nxt = S_EMIT;
         S_EMIT:   state_nxt = last_q ? S_IDLE : S_DRAIN;
         S_DRAIN:  if (hs && rx_last) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Packet field capture
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         round_q <= '0;
         src_q   <= '0;
         hops_q  <= '0;
         qv_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         if (cap_hdr)  round_q <= hdr.round;
         if (cap_src)  src_q   <= rx_data;
         if (cap_hops) hops_q  <= rx_data;
         if (cap_qv)   qv_q    <= rx_data;
         if (set_last) last_q  <= rx_last;
      end
   end

   // Stored heartbeat round; invalid until the first round is seen
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rnd_q     <= '0;
         rnd_valid <= 1'b0;
      end else if (state_nxt == S_RND) begin
         rnd_q     <= round_q;
         rnd_valid <= 1'b1;
      end
   end

   // Registered handshake and strobes, decoded from the upcoming state
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_ready <= 1'b0;
         en_KCH   <= 1'b0;
         HB_reset <= 1'b0;
      end else begin
         rx_ready <= accepts_word(state_nxt);
         en_KCH   <= (state_nxt == S_EMIT);
         HB_reset <= (state_nxt == S_RND);
      end
   end

   // CH entry and counters; entry loads so it is valid alongside en_KCH
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fCH_ID     <= '0;
         fCH_Hops   <= HOPS_INF;
         fCH_QValue <= '0;
         hb_count   <= '0;
         err_count  <= '0;
      end else begin
         if (state_nxt == S_EMIT) begin
            fCH_ID     <= src_q;
            fCH_Hops   <= hops_inc(hops_q);
            fCH_QValue <= qv_q;
            hb_count   <= hb_count + WORD_WIDTH'(1);
         end
         if (err_inc && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hb_rx_parser.sv
// Scoreboard bench for hb_rx_parser: expected strobes are queued by the
// stimulus, a forked monitor pops and compares on every strobe.
module tb_hb_rx_parser;
   import eerrl_pkg::*;

   logic                  clk = 1'b0;
   logic                  nrst;
   logic [WORD_WIDTH-1:0] my_id;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [WORD_WIDTH-1:0] rx_data;
   logic                  rx_last;
   logic                  en_KCH;
   logic                  HB_reset;
   logic [WORD_WIDTH-1:0] fCH_ID;
   logic [WORD_WIDTH-1:0] fCH_Hops;
   logic [WORD_WIDTH-1:0] fCH_QValue;
   logic [WORD_WIDTH-1:0] hb_count;
   logic [ERR_W-1:0]      err_count;

   typedef struct {
      bit          is_rst;
      logic [15:0] id;
      logic [15:0] hops;
      logic [15:0] qv;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] pkt [0:7];
   int          exp_err;

   always #5 clk = ~clk;

   hb_rx_parser dut (
      .clk        (clk),
      .nrst       (nrst),
      .my_id      (my_id),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_last    (rx_last),
      .en_KCH     (en_KCH),
      .HB_reset   (HB_reset),
      .fCH_ID     (fCH_ID),
      .fCH_Hops   (fCH_Hops),
      .fCH_QValue (fCH_QValue),
      .hb_count   (hb_count),
      .err_count  (err_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_rst();
      exp_t e;
      e.is_rst = 1'b1; e.id = '0; e.hops = '0; e.qv = '0; e.cnt = '0;
      sb.push_back(e);
   endtask

   task automatic push_emit(input logic [15:0] id, input logic [15:0] hops,
                            input logic [15:0] qv, input logic [15:0] cnt);
      exp_t e;
      e.is_rst = 1'b0; e.id = id; e.hops = hops; e.qv = qv; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // Monitor: pops one expectation per observed strobe
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (nrst && HB_reset) begin
            if (sb.size() == 0) chk("unexpected_HB_reset", 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk("HB_reset_kind", {31'd0, e.is_rst}, 32'd1);
            end
         end
         if (nrst && en_KCH) begin
            if (sb.size() == 0) chk("unexpected_en_KCH", 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk("en_KCH_kind", {31'd0, e.is_rst}, 32'd0);
               if (!e.is_rst) begin
                  chk("fCH_ID", {16'd0, fCH_ID}, {16'd0, e.id});
                  chk("fCH_Hops", {16'd0, fCH_Hops}, {16'd0, e.hops});
                  chk("fCH_QValue", {16'd0, fCH_QValue}, {16'd0, e.qv});
                  chk("hb_count_at_emit", {16'd0, hb_count}, {16'd0, e.cnt});
               end
            end
         end
      end
   endtask

   // Drives pkt[0..n-1]; optional random valid bubbles; rx_last on the final word if last_end
   task automatic send(input int n, input bit bub, input bit last_end);
      bit hs;
      int budget;
      for (int i = 0; i < n; i++) begin
         budget = 0;
         hs = 1'b0;
         while (!hs) begin
            rx_valid = (bub && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
            rx_data  = pkt[i];
            rx_last  = last_end && (i == n - 1);
            @(negedge clk);
            hs = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!hs && budget > 50) begin
               chk("handshake_timeout", 32'd1, 32'd0);
               hs = 1'b1;
            end
         end
      end
      rx_valid = 1'b0;
      rx_last  = 1'b0;
   endtask

   // Heartbeat-shaped packet, with checksum word when enabled and optional trailing words
   task automatic hb_pkt(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3, input int extra, input bit bub);
      int n;
      pkt[0] = w0; pkt[1] = w1; pkt[2] = w2; pkt[3] = w3;
      n = 4;
`ifdef HB_CHECKSUM_EN
      pkt[4] = w0 ^ w1 ^ w2 ^ w3;
      n = 5;
`endif
      for (int k = 0; k < extra; k++) begin
         pkt[n] = 16'hDEAD + 16'(k);
         n++;
      end
      send(n, bub, 1'b1);
   endtask

   task automatic settle();
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 40) begin
         @(posedge clk);
         budget++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("sb_pending", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst     = 1'b0;
      my_id    = 16'h0003;
      rx_valid = 1'b0;
      rx_data  = '0;
      rx_last  = 1'b0;
      exp_err  = 0;
      fork
         monitor();
      join_none

      // Reset values
      repeat (4) @(posedge clk);
      #1;
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_en_KCH", {31'd0, en_KCH}, 32'd0);
      chk("rst_HB_reset", {31'd0, HB_reset}, 32'd0);
      chk("rst_fCH_ID", {16'd0, fCH_ID}, 32'd0);
      chk("rst_fCH_Hops", {16'd0, fCH_Hops}, 32'h0000FFFF);
      chk("rst_fCH_QValue", {16'd0, fCH_QValue}, 32'd0);
      chk("rst_hb_count", {16'd0, hb_count}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", {31'd0, rx_ready}, 32'd1);

      // First heartbeat of round 5: new round then entry
      push_rst();
      push_emit(16'd7, 16'd3, 16'h0040, 16'd1);
      hb_pkt(16'h0105, 16'h0007, 16'h0002, 16'h0040, 0, 1'b0);
      settle();

      // Same round from another CH, hops 0
      push_emit(16'd9, 16'd1, 16'h0011, 16'd2);
      hb_pkt(16'h0105, 16'h0009, 16'h0000, 16'h0011, 0, 1'b0);
      settle();

      // Silent drops: own ID, unreachable CH, non-HB type (with trailing words)
      hb_pkt(16'h0105, 16'h0003, 16'h0001, 16'h0005, 0, 1'b0);
      hb_pkt(16'h0105, 16'h0008, 16'hFFFF, 16'h0005, 1, 1'b0);
      hb_pkt(16'h0201, 16'h0008, 16'h0001, 16'h0005, 2, 1'b0);
      settle();
      chk("drop_err_count", {24'd0, err_count}, 32'd0);
      chk("drop_hb_count", {16'd0, hb_count}, 32'd2);
      chk("drop_back_idle_ready", {31'd0, rx_ready}, 32'd1);

      // Short packet ending on w1
      pkt[0] = 16'h0105; pkt[1] = 16'h0007;
      send(2, 1'b0, 1'b1);
      exp_err = 1;
      settle();
      chk("short_err_count", {24'd0, err_count}, 32'(exp_err));

      // Hops 0xFFFE saturates to 0xFFFF
      push_emit(16'h000A, 16'hFFFF, 16'h0022, 16'd3);
      hb_pkt(16'h0105, 16'h000A, 16'hFFFE, 16'h0022, 0, 1'b0);
      settle();

      // New round 6 with a trailing extra word that must be drained
      push_rst();
      push_emit(16'd4, 16'd6, 16'h0033, 16'd4);
      hb_pkt(16'h0106, 16'h0004, 16'h0005, 16'h0033, 1, 1'b0);
      settle();

`ifdef HB_CHECKSUM_EN
      // Corrupted checksum word
      pkt[0] = 16'h0106; pkt[1] = 16'h0007; pkt[2] = 16'h0002; pkt[3] = 16'h0040;
      pkt[4] = (16'h0106 ^ 16'h0007 ^ 16'h0002 ^ 16'h0040) ^ 16'h0001;
      send(5, 1'b0, 1'b1);
      exp_err++;
      settle();
      chk("bad_chk_err_count", {24'd0, err_count}, 32'(exp_err));
      chk("bad_chk_hb_count", {16'd0, hb_count}, 32'd4);
`endif

      // Random valid bubbles, new round 7
      push_rst();
      push_emit(16'd7, 16'd3, 16'h0040, 16'd5);
      hb_pkt(16'h0107, 16'h0007, 16'h0002, 16'h0040, 0, 1'b1);
      settle();
      chk("bubble_err_count", {24'd0, err_count}, 32'(exp_err));

      // Async reset mid-packet
      pkt[0] = 16'h0107; pkt[1] = 16'h0007;
      send(2, 1'b0, 1'b0);
      nrst = 1'b0;
      #1;
      chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("midrst_fCH_Hops", {16'd0, fCH_Hops}, 32'h0000FFFF);
      chk("midrst_hb_count", {16'd0, hb_count}, 32'd0);
      chk("midrst_err_count", {24'd0, err_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;

      // Stored round is invalid again: round 7 restarts a round
      push_rst();
      push_emit(16'd7, 16'd3, 16'h0040, 16'd1);
      hb_pkt(16'h0107, 16'h0007, 16'h0002, 16'h0040, 0, 1'b0);
      settle();
      chk("final_hb_count", {16'd0, hb_count}, 32'd1);
      chk("final_err_count", {24'd0, err_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
